// File: rtl/freq_scan_ctrl.sv
// freq_scan_ctrl: time-shares one 32-bit period counter across CHANNELS
// inputs. Each channel is selected in turn; the counter arms on a rising edge
// and counts clk cycles to the next rising edge, then stores the period.
// Ports: clk, rst (sync, active high), enable, signals, ch_mask -> periods
// (32 bits per channel), valid, timeout_flags, active_ch, busy, sweep_done.
// Build option FREQ_SCAN_HOLD_EN: a timeout keeps the old period and valid bit
// and only sets timeout_flags.
module freq_scan_ctrl #(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CHANNELS-1:0]      signals,
  input  logic [CHANNELS-1:0]      ch_mask,
  output logic [32*CHANNELS-1:0]   periods,
  output logic [CHANNELS-1:0]      valid,
  output logic [CHANNELS-1:0]      timeout_flags,
  output logic [3:0]               active_ch,
  output logic                     busy,
  output logic                     sweep_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ARM, S_MEAS, S_STORE, S_TOUT
  } state_t;

  state_t              state, nxt;
  logic [CHANNELS-1:0] s1, s2, hist, rise;
  logic [15:0]         mask16, rise16;
  logic [3:0]          ptr, ptr_step, ptr_adv;
  logic [31:0]         cnt, result;
  logic [31:0]         per_q [CHANNELS];
  logic                en_q, last_ch, rise_sel, sel_hit;

  // Two-flop synchronizer plus history flop; equal latency on every edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
    end else begin
      s1   <= signals;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign rise     = s2 & ~hist;
  assign mask16   = 16'(ch_mask);
  assign rise16   = 16'(rise);
  assign rise_sel = rise16[active_ch];
  assign sel_hit  = mask16[ptr];

  assign ptr_step = (ptr == 4'(CHANNELS-1)) ? 4'd0 : ptr + 4'd1;
  assign ptr_adv  = (active_ch == 4'(CHANNELS-1)) ? 4'd0
                                                  : active_ch + 4'd1;

  // Current channel is the last of the sweep when no higher bit is unmasked.
  always_comb begin
    last_ch = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i > int'(active_ch) && ch_mask[i]) last_ch = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!enable) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (ch_mask != '0) nxt = S_SELECT;
        S_SELECT: begin
          if (ch_mask == '0) nxt = S_IDLE;
          else if (sel_hit)  nxt = S_ARM;
        end
        S_ARM: begin
          if (rise_sel)                        nxt = S_MEAS;
          else if (cnt == 32'(TIMEOUT - 1))    nxt = S_TOUT;
        end
        // Timing out at cnt = TIMEOUT-2 makes TIMEOUT-1 the longest
        // storable period; an edge in that same cycle still wins.
        S_MEAS: begin
          if (rise_sel)                        nxt = S_STORE;
          else if (cnt == 32'(TIMEOUT - 2))    nxt = S_TOUT;
        end
        S_STORE:  nxt = S_SELECT;
        S_TOUT:   nxt = S_SELECT;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      active_ch     <= '0;
      cnt           <= '0;
      result        <= '0;
      valid         <= '0;
      timeout_flags <= '0;
      sweep_done    <= 1'b0;
      en_q          <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) per_q[i] <= '0;
    end else begin
      en_q       <= enable;
      sweep_done <= 1'b0;
      if (enable && !en_q) valid <= '0;
      if (enable) begin
        unique case (state)
          S_SELECT: begin
            if (sel_hit) begin
              active_ch <= ptr;
              cnt       <= '0;
            end else if (ch_mask != '0) begin
              ptr <= ptr_step;
            end
          end
          S_ARM: begin
            if (rise_sel) cnt <= '0;
            else          cnt <= cnt + 32'd1;
          end
          S_MEAS: begin
            if (rise_sel) result <= cnt + 32'd1;
            else          cnt    <= cnt + 32'd1;
          end
          S_STORE: begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (4'(i) == active_ch) begin
                per_q[i]         <= result;
                valid[i]         <= 1'b1;
                timeout_flags[i] <= 1'b0;
              end
            end
            ptr        <= ptr_adv;
            sweep_done <= last_ch;
          end
          S_TOUT: begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (4'(i) == active_ch) begin
`ifdef FREQ_SCAN_HOLD_EN
                timeout_flags[i] <= 1'b1;
`else
                per_q[i]         <= '0;
                valid[i]         <= 1'b0;
                timeout_flags[i] <= 1'b1;
`endif
              end
            end
            ptr        <= ptr_adv;
            sweep_done <= last_ch;
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign periods[32*g +: 32] = per_q[g];
  end

endmodule
